tlb_access_scheduler: RTL

//  Shares the single TLB search/read/write port among three requesters: instruction fetch

---
 rtl/tlb_access_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tlb_access_scheduler.sv
// TLB access scheduler: arbitrates the single TLB port between instruction
// fetch search, data-memory search and CP0 TLB instructions. Search results
// are registered (one-cycle latency). A CP0 op holds every requester off for
// one extra cycle so that no search sees a half-written entry. Also owns
// the free-running TLBWR random index.
//
// cp0_entry layout: [39:21] vpn, [20:13] asid, [12:0] EntryLo image.
// Request layout:   [27:9] vpn, [8] is_odd_page, [7:0] asid.
module tlb_access_scheduler #(
    parameter int TLB_NUM = 16,
    parameter int IDX_W   = $clog2(TLB_NUM)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inst_req_valid,
    output logic             inst_req_ready,
    input  logic [27:0]      inst_req,
    output logic             inst_resp_valid,
    output logic [10:0]      inst_resp,
    input  logic             data_req_valid,
    output logic             data_req_ready,
    input  logic [27:0]      data_req,
    output logic             data_resp_valid,
    output logic [10:0]      data_resp,
    input  logic             cp0_op_valid,
    output logic             cp0_op_ready,
    input  logic [1:0]       cp0_op,
    input  logic [IDX_W-1:0] cp0_index,
    input  logic [39:0]      cp0_entry,
    output logic             cp0_done,
    output logic [10:0]      cp0_probe,
    output logic [39:0]      cp0_read_entry,
    output logic [27:0]      tlb_search_req,
    input  logic [10:0]      tlb_search_res,
    output logic [IDX_W-1:0] tlb_read_index,
    input  logic [39:0]      tlb_read_entry,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_write_index,
    output logic [39:0]      tlb_write_entry
);

    typedef enum logic {IDLE, CP0_RESP} state_t;
    typedef enum logic {REQ_INST, REQ_DATA} req_t;
    typedef enum logic [1:0] {OP_TLBP = 2'b00, OP_TLBR = 2'b01,
                              OP_TLBWI = 2'b10, OP_TLBWR = 2'b11} cp0_op_t;

    state_t           state_q, state_d;
    req_t             rr_last_q, rr_last_d;
    logic [IDX_W-1:0] random_q, random_d;
    logic             inst_resp_valid_q, inst_resp_valid_d;
    logic             data_resp_valid_q, data_resp_valid_d;
    logic [10:0]      inst_resp_q, inst_resp_d;
    logic [10:0]      data_resp_q, data_resp_d;
    logic [10:0]      cp0_probe_q, cp0_probe_d;
    logic [39:0]      cp0_read_entry_q, cp0_read_entry_d;
    logic             inst_grant, data_grant, cp0_grant;
    cp0_op_t          op;

    // Grant selection, next state, TLB port muxing and result capture.
    always_comb begin
        op                = cp0_op_t'(cp0_op);
        state_d           = state_q;
        rr_last_d         = rr_last_q;
        inst_grant        = 1'b0;
        data_grant        = 1'b0;
        cp0_grant         = 1'b0;
        tlb_search_req    = '0;
        tlb_we            = 1'b0;

        if (state_q == IDLE && !reset) begin
            if (cp0_op_valid) begin
                cp0_grant = 1'b1;
                state_d   = CP0_RESP;
            end else if (inst_req_valid && data_req_valid) begin
                if (rr_last_q == REQ_DATA) inst_grant = 1'b1;
                else                       data_grant = 1'b1;
            end else if (inst_req_valid) begin
                inst_grant = 1'b1;
            end else if (data_req_valid) begin
                data_grant = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end

        if (inst_grant) rr_last_d = REQ_INST;
        if (data_grant) rr_last_d = REQ_DATA;

        if (inst_grant)
            tlb_search_req = inst_req;
        else if (data_grant)
            tlb_search_req = data_req;
        else if (cp0_grant && op == OP_TLBP)
            tlb_search_req = {cp0_entry[39:21], 1'b0, cp0_entry[20:13]};

        if (cp0_grant && (op == OP_TLBWI || op == OP_TLBWR))
            tlb_we = 1'b1;

        inst_resp_valid_d = inst_grant;
        data_resp_valid_d = data_grant;
        inst_resp_d       = inst_grant ? tlb_search_res : inst_resp_q;
        data_resp_d       = data_grant ? tlb_search_res : data_resp_q;
        cp0_probe_d       = (cp0_grant && op == OP_TLBP) ? tlb_search_res : cp0_probe_q;
        cp0_read_entry_d  = (cp0_grant && op == OP_TLBR) ? tlb_read_entry : cp0_read_entry_q;

        random_d = (random_q == '0) ? IDX_W'(TLB_NUM - 1) : random_q - IDX_W'(1);
    end

    assign inst_req_ready  = inst_grant;
    assign data_req_ready  = data_grant;
    assign cp0_op_ready    = cp0_grant;
    assign cp0_done        = (state_q == CP0_RESP);
    assign inst_resp_valid = inst_resp_valid_q;
    assign data_resp_valid = data_resp_valid_q;
    assign inst_resp       = inst_resp_q;
    assign data_resp       = data_resp_q;
    assign cp0_probe       = cp0_probe_q;
    assign cp0_read_entry  = cp0_read_entry_q;
    assign tlb_read_index  = cp0_index;
    assign tlb_write_index = (op == OP_TLBWR) ? random_q : cp0_index;
    assign tlb_write_entry = cp0_entry;

    // State, arbitration history, random counter and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            rr_last_q         <= REQ_DATA;
            random_q          <= IDX_W'(TLB_NUM - 1);
            inst_resp_valid_q <= 1'b0;
            data_resp_valid_q <= 1'b0;
            inst_resp_q       <= '0;
            data_resp_q       <= '0;
            cp0_probe_q       <= '0;
            cp0_read_entry_q  <= '0;
        end else begin
            state_q           <= state_d;
            rr_last_q         <= rr_last_d;
            random_q          <= random_d;
            inst_resp_valid_q <= inst_resp_valid_d;
            data_resp_valid_q <= data_resp_valid_d;
            inst_resp_q       <= inst_resp_d;
            data_resp_q       <= data_resp_d;
            cp0_probe_q       <= cp0_probe_d;
            cp0_read_entry_q  <= cp0_read_entry_d;
        end
    end

endmodule
